// File: rtl/fwd_hazard_unit_n_pkg.sv
// Shared definitions for the ID-stage forwarding / hazard unit:
// default widths, branch/JR stall FSM encoding and counter type.
package fwd_hazard_unit_n_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int BJ_CNT_W       = 4;

  typedef logic [BJ_CNT_W-1:0] bj_cnt_t;

  localparam logic [0:0] BJ_IDLE = 1'b0;
  localparam logic [0:0] BJ_WAIT = 1'b1;

endpackage

// File: rtl/fwd_hazard_unit_n_src_select.sv
// Per-source forwarding selector: finds the youngest downstream writer of
// one source register and reports whether its result can be forwarded or
// whether the ID stage must stall for it.
module fwd_src_select #(
  parameter int NUM_STAGES = 2,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]            src_addr,
  input  logic                             src_used,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_dst,
  input  logic [NUM_STAGES-1:0]            stage_wen,
  input  logic [NUM_STAGES-1:0]            stage_rdy,
  input  logic [NUM_STAGES*DATA_W-1:0]     stage_data,
  output logic                             hit_any,
  output logic                             fwd,
  output logic                             not_ready,
  output logic [DATA_W-1:0]                fwd_data
);

  logic [NUM_STAGES-1:0] hit;
  logic                  found;
  logic                  win_rdy;
  logic [DATA_W-1:0]     win_data;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_hit
    // Register 0 is hard-wired, so a write to it is never a real producer.
    assign hit[s] = src_used & stage_wen[s]
                  & (stage_dst[s*REG_ADDR_W +: REG_ADDR_W] == src_addr)
                  & (stage_dst[s*REG_ADDR_W +: REG_ADDR_W] != '0);
  end

  // Priority scan from oldest to youngest so the youngest hit overrides.
  always_comb begin
    found    = 1'b0;
    win_rdy  = 1'b0;
    win_data = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (hit[s]) begin
        found    = 1'b1;
        win_rdy  = stage_rdy[s];
        win_data = stage_data[s*DATA_W +: DATA_W];
      end
    end
  end

  assign hit_any   = |hit;
  assign fwd       = found & win_rdy;
  assign not_ready = found & ~win_rdy;
  assign fwd_data  = fwd ? win_data : '0;

endmodule

// File: rtl/fwd_hazard_unit_n.sv
// ID-stage operand forwarding and hazard unit.
// Compares NUM_SRC source registers against NUM_STAGES downstream writers
// (index 0 youngest), registers forward select/data for the next stage,
// raises a not-ready stall and sequences the branch/JR resolution stall.
// Optional build macro FWD_STATS_EN adds saturating forward/stall counters.
module fwd_hazard_unit_n
  import fwd_hazard_unit_n_pkg::*;
#(
  parameter int NUM_SRC         = 2,
  parameter int NUM_STAGES      = 2,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int REG_ADDR_W      = DEF_REG_ADDR_W,
  parameter int BJ_STALL_CYCLES = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             PIPELINE_READY,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr,
  input  logic [NUM_SRC-1:0]               src_used,
  input  logic                             s_branch_jr,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_dst,
  input  logic [NUM_STAGES-1:0]            stage_wen,
  input  logic [NUM_STAGES-1:0]            stage_rdy,
  input  logic [NUM_STAGES*DATA_W-1:0]     stage_data,
  output logic                             s_stall,
  output logic                             s_branch_jr_ok,
  output logic [NUM_SRC-1:0]               s_fwd,
  output logic [NUM_SRC-1:0]               s_fwd_bj,
  output logic [NUM_SRC*DATA_W-1:0]        d_fwd
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                      stat_fwd_cnt,
  output logic [31:0]                      stat_stall_cnt
`endif
);

  localparam bj_cnt_t BJ_LOAD = bj_cnt_t'(BJ_STALL_CYCLES - 1);

  logic [NUM_SRC-1:0]        fwd_p0;
  logic [NUM_SRC-1:0]        nr_p0;
  logic [NUM_SRC-1:0]        hit_p0;
  logic [NUM_SRC*DATA_W-1:0] data_p0;
  logic                      bj_hit_p0;

  logic [NUM_SRC-1:0]        s_fwd_p1;
  logic [NUM_SRC-1:0]        s_fwd_bj_p1;
  logic [NUM_SRC*DATA_W-1:0] d_fwd_p1;

  logic [0:0]                bj_state;
  bj_cnt_t                   bj_cnt;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_select #(
      .NUM_STAGES (NUM_STAGES),
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_sel (
      .src_addr   (src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .src_used   (src_used[i]),
      .stage_dst  (stage_dst),
      .stage_wen  (stage_wen),
      .stage_rdy  (stage_rdy),
      .stage_data (stage_data),
      .hit_any    (hit_p0[i]),
      .fwd        (fwd_p0[i]),
      .not_ready  (nr_p0[i]),
      .fwd_data   (data_p0[i*DATA_W +: DATA_W])
    );
  end

  assign s_stall        = |nr_p0;
  assign bj_hit_p0      = s_branch_jr & (|hit_p0);
  assign s_branch_jr_ok = ~s_branch_jr | ~bj_hit_p0
                        | ((bj_state == BJ_WAIT) & (bj_cnt == '0));

  // ---- stage p0 -> p1: forward select/data registered for the next stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_fwd_p1    <= '0;
      s_fwd_bj_p1 <= '0;
      d_fwd_p1    <= '0;
    end else if (PIPELINE_READY) begin
      s_fwd_p1    <= fwd_p0;
      s_fwd_bj_p1 <= fwd_p0 & {NUM_SRC{s_branch_jr}};
      d_fwd_p1    <= data_p0;
    end
  end

  assign s_fwd    = s_fwd_p1;
  assign s_fwd_bj = s_fwd_bj_p1;
  assign d_fwd    = d_fwd_p1;

  // Branch/JR stall sequencer; a not-ready stall freezes it entirely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bj_state <= BJ_IDLE;
      bj_cnt   <= '0;
    end else if (PIPELINE_READY && !s_stall) begin
      if (bj_state == BJ_IDLE) begin
        if (bj_hit_p0) begin
          bj_state <= BJ_WAIT;
          bj_cnt   <= BJ_LOAD;
        end
      end else begin
        if (bj_cnt == '0) bj_state <= BJ_IDLE;
        else              bj_cnt   <= bj_cnt - bj_cnt_t'(1);
      end
    end
  end

`ifdef FWD_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Saturating activity counters for forwarding and ID stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_fwd_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (PIPELINE_READY && (|fwd_p0))     stat_fwd_cnt   <= sat_inc32(stat_fwd_cnt);
      if (s_stall || !s_branch_jr_ok)      stat_stall_cnt <= sat_inc32(stat_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit_n.sv
// Scoreboard bench for fwd_hazard_unit_n (2 sources, 2 stages,
// BJ_STALL_CYCLES=2). Directed vectors carry hand-computed expectations.
module tb_fwd_hazard_unit_n;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        PIPELINE_READY = 1'b0;
  logic [9:0]  src_addr = '0;
  logic [1:0]  src_used = '0;
  logic        s_branch_jr = 1'b0;
  logic [9:0]  stage_dst = '0;
  logic [1:0]  stage_wen = '0;
  logic [1:0]  stage_rdy = '0;
  logic [63:0] stage_data = '0;
  logic        s_stall;
  logic        s_branch_jr_ok;
  logic [1:0]  s_fwd;
  logic [1:0]  s_fwd_bj;
  logic [63:0] d_fwd;
`ifdef FWD_STATS_EN
  logic [31:0] stat_fwd_cnt;
  logic [31:0] stat_stall_cnt;
`endif

  fwd_hazard_unit_n #(
    .NUM_SRC(2), .NUM_STAGES(2), .DATA_W(32), .REG_ADDR_W(5), .BJ_STALL_CYCLES(2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .PIPELINE_READY (PIPELINE_READY),
    .src_addr       (src_addr),
    .src_used       (src_used),
    .s_branch_jr    (s_branch_jr),
    .stage_dst      (stage_dst),
    .stage_wen      (stage_wen),
    .stage_rdy      (stage_rdy),
    .stage_data     (stage_data),
    .s_stall        (s_stall),
    .s_branch_jr_ok (s_branch_jr_ok),
    .s_fwd          (s_fwd),
    .s_fwd_bj       (s_fwd_bj),
    .d_fwd          (d_fwd)
`ifdef FWD_STATS_EN
    ,
    .stat_fwd_cnt   (stat_fwd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        pr;
    logic        e_stall;
    logic        e_ok;
    logic [1:0]  e_fwd;
    logic [1:0]  e_bj;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    string       nm;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expectation.
  task automatic vec(input logic rn, input logic pr, input logic bj,
                     input logic [1:0] used, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [1:0] wen, input logic [1:0] rdy,
                     input logic [4:0] d0, input logic [4:0] d1,
                     input logic [31:0] da0, input logic [31:0] da1,
                     input logic e_stall, input logic e_ok,
                     input logic [1:0] e_fwd, input logic [1:0] e_bj,
                     input logic [31:0] e_d0, input logic [31:0] e_d1,
                     input string nm);
    item_t it;
    @(negedge clk);
    reset_n        = rn;
    PIPELINE_READY = pr;
    s_branch_jr    = bj;
    src_used       = used;
    src_addr       = {a1, a0};
    stage_wen      = wen;
    stage_rdy      = rdy;
    stage_dst      = {d1, d0};
    stage_data     = {da1, da0};
    it.rn = rn; it.pr = pr; it.e_stall = e_stall; it.e_ok = e_ok;
    it.e_fwd = e_fwd; it.e_bj = e_bj; it.e_d0 = e_d0; it.e_d1 = e_d1; it.nm = nm;
    q.push_back(it);
    pushed++;
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin
    item_t it;
    logic [31:0] exp_fc;
    logic [31:0] exp_sc;
    exp_fc = '0;
    exp_sc = '0;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk({it.nm, ".stall"}, 32'(s_stall), 32'(it.e_stall));
        chk({it.nm, ".bj_ok"}, 32'(s_branch_jr_ok), 32'(it.e_ok));
        if (!it.rn) begin
          chk({it.nm, ".rst_fwd_now"}, 32'(s_fwd), 32'd0);
          chk({it.nm, ".rst_d_now"}, d_fwd[31:0] | d_fwd[63:32], 32'd0);
        end
        @(posedge clk);
        #1;
        chk({it.nm, ".s_fwd"}, 32'(s_fwd), 32'(it.e_fwd));
        chk({it.nm, ".s_fwd_bj"}, 32'(s_fwd_bj), 32'(it.e_bj));
        chk({it.nm, ".d_fwd0"}, d_fwd[31:0], it.e_d0);
        chk({it.nm, ".d_fwd1"}, d_fwd[63:32], it.e_d1);
        if (!it.rn) begin
          exp_fc = '0;
          exp_sc = '0;
        end else begin
          if (it.pr && (it.e_fwd != 2'b00)) exp_fc = exp_fc + 32'd1;
          if (it.e_stall || !it.e_ok)       exp_sc = exp_sc + 32'd1;
        end
`ifdef FWD_STATS_EN
        chk({it.nm, ".stat_fwd"}, stat_fwd_cnt, exp_fc);
        chk({it.nm, ".stat_stall"}, stat_stall_cnt, exp_sc);
`endif
        done_cnt++;
      end
    end
  end

  // Stimulus
  initial begin
    // rn pr bj used a0 a1 wen rdy d0 d1 da0 da1 | stall ok fwd bj d0 d1
    vec(0,0,0,2'b00,0,0,2'b00,2'b00,0,0,0,0,           0,1,2'b00,2'b00,0,0,"reset");
    vec(1,1,0,2'b01,3,0,2'b11,2'b11,3,3,'h11,'h22,     0,1,2'b01,2'b00,'h11,0,"fwd_youngest");
    vec(1,1,0,2'b10,0,0,2'b11,2'b11,0,0,'h11,'h22,     0,1,2'b00,2'b00,0,0,"reg0_nohit");
    vec(1,1,0,2'b01,5,0,2'b11,2'b10,5,5,'h55,'h66,     1,1,2'b00,2'b00,0,0,"notready_stall");
    vec(1,1,0,2'b01,5,0,2'b10,2'b10,5,5,'h55,'h66,     0,1,2'b01,2'b00,'h66,0,"older_fwd");
    vec(1,1,0,2'b11,7,9,2'b11,2'b11,9,7,'hAAAA0001,'hBBBB0002,
                                                       0,1,2'b11,2'b00,'hBBBB0002,'hAAAA0001,"two_src");
    vec(1,0,0,2'b01,3,0,2'b01,2'b01,3,0,'h33,0,        0,1,2'b11,2'b00,'hBBBB0002,'hAAAA0001,"hold");
    // branch whose src0 hits stage1: two not-ok ready cycles, then ok
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b01,2'b01,'h44,0,"bj_c0");
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b01,2'b01,'h44,0,"bj_c1");
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,1,2'b01,2'b01,'h44,0,"bj_c2");
    // restart, then pipeline held three cycles: counter must not move
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b01,2'b01,'h44,0,"bj_restart");
    for (int k = 0; k < 3; k++)
      vec(1,0,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,      0,0,2'b01,2'b01,'h44,0,"bj_hold");
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b01,2'b01,'h44,0,"bj_resume");
    vec(1,0,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,1,2'b01,2'b01,'h44,0,"bj_ok_held");
    // not-ready stall while in WAIT with cnt==0 freezes the sequencer
    vec(1,1,1,2'b01,4,0,2'b10,2'b01,0,4,0,'h44,        1,1,2'b00,2'b00,0,0,"bj_wait_stall");
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,1,2'b01,2'b01,'h44,0,"bj_wait_done");
    // not-ready stall dominates in IDLE: count starts only after it drops
    vec(1,1,1,2'b01,4,0,2'b10,2'b01,0,4,0,'h44,        1,0,2'b00,2'b00,0,0,"bj_idle_stall0");
    vec(1,1,1,2'b01,4,0,2'b10,2'b01,0,4,0,'h44,        1,0,2'b00,2'b00,0,0,"bj_idle_stall1");
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b01,2'b01,'h44,0,"bj_start");
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b01,2'b01,'h44,0,"bj_count");
    // reset mid-WAIT (cnt==0): ok would be high without it
    vec(0,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b00,2'b00,0,0,"reset_mid_wait");
    vec(1,1,1,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,0,2'b01,2'b01,'h44,0,"after_reset");
    vec(1,1,0,2'b01,4,0,2'b10,2'b11,0,4,0,'h44,        0,1,2'b01,2'b00,'h44,0,"no_branch");

    for (int k = 0; k < 50 && done_cnt < pushed; k++) @(posedge clk);
    if (done_cnt < pushed) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=%0d", done_cnt, pushed);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
